// File: rtl/neuron_pkg.sv
// Shared types and constants for the single-neuron perceptron training slice.
// Datapath field widths live here so the top level sizes its registers consistently.
package neuron_pkg;

    localparam int unsigned DefEpochW    = 8;
    localparam int unsigned DefMaxEpochs = 100;

    localparam int unsigned XWidth = 7;
    localparam int unsigned TWidth = 2;
    localparam int unsigned WWidth = 14;
    localparam int unsigned NWidth = 20;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StFetch,
        StEval,
        StCheck,
        StEpochEnd,
        StDone
    } train_state_t;

endpackage

// File: rtl/neuron_train_ctrl.sv
// Training sequencer for the perceptron datapath: fetches samples, commits weight updates
// on misclassification, and counts epochs until an error-free epoch or the epoch limit.
module neuron_train_ctrl
    import neuron_pkg::*;
#(
    parameter int unsigned EPOCH_W    = DefEpochW,
    parameter int unsigned MAX_EPOCHS = DefMaxEpochs
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               epoch_start,
    input  logic               yEqualt,
    input  logic               flagEOF,
    output logic               reset,
    output logic               ldRegN,
    output logic               ldRegx1,
    output logic               ldRegx2,
    output logic               ldRegT,
    output logic               ldRegW1,
    output logic               ldRegW2,
    output logic               ldRegB,
    output logic               ldRegFlag,
    output logic               counterEn,
    output logic               counterReset,
    output logic               flagReset,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epochs
);

    localparam logic [EPOCH_W-1:0] LastEpoch = EPOCH_W'(MAX_EPOCHS - 1);

    train_state_t state;
    logic         errSeen;
    logic         lastEpoch;

    // The epoch being closed in EPOCH_END is the final one allowed.
    assign lastEpoch = (epochs == LastEpoch);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            errSeen   <= 1'b0;
            epochs    <= '0;
            converged <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StInit;
                        epochs    <= '0;
                        converged <= 1'b0;
                        errSeen   <= 1'b0;
                    end
                end
                StInit: state <= StCheck;
                StFetch: begin
                    if (sample_valid) begin
                        state <= StEval;
                    end
                end
                StEval: begin
                    if (!yEqualt) begin
                        errSeen <= 1'b1;
                    end
                    state <= StCheck;
                end
                StCheck: state <= flagEOF ? StEpochEnd : StFetch;
                StEpochEnd: begin
                    if (epochs != '1) begin
                        epochs <= epochs + 1'b1;
                    end
                    if (!errSeen) begin
                        converged <= 1'b1;
                        state     <= StDone;
                    end else if (lastEpoch) begin
                        state <= StDone;
                    end else begin
                        errSeen <= 1'b0;
                        state   <= StFetch;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        sample_ready = 1'b0;
        epoch_start  = 1'b0;
        reset        = 1'b0;
        ldRegN       = 1'b0;
        ldRegx1      = 1'b0;
        ldRegx2      = 1'b0;
        ldRegT       = 1'b0;
        ldRegW1      = 1'b0;
        ldRegW2      = 1'b0;
        ldRegB       = 1'b0;
        ldRegFlag    = 1'b0;
        counterEn    = 1'b0;
        counterReset = 1'b0;
        flagReset    = 1'b0;
        done         = 1'b0;
        busy         = (state != StIdle);
        unique case (state)
            StInit: begin
                reset        = 1'b1;
                ldRegN       = 1'b1;
                counterReset = 1'b1;
                flagReset    = 1'b1;
            end
            StFetch: begin
                sample_ready = 1'b1;
                // Sample registers load on the handshake edge itself.
                if (sample_valid) begin
                    ldRegx1 = 1'b1;
                    ldRegx2 = 1'b1;
                    ldRegT  = 1'b1;
                end
            end
            StEval: begin
                counterEn = 1'b1;
                ldRegFlag = 1'b1;
                if (!yEqualt) begin
                    ldRegW1 = 1'b1;
                    ldRegW2 = 1'b1;
                    ldRegB  = 1'b1;
                end
            end
            StEpochEnd: begin
                if (errSeen && !lastEpoch) begin
                    counterReset = 1'b1;
                    flagReset    = 1'b1;
                    epoch_start  = 1'b1;
                end
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Scoreboard bench for neuron_train_ctrl: stimulus queues expected run results and
// point-in-time output checks; a negedge monitor pops and compares them.
module tb_neuron_train_ctrl;

    localparam int unsigned EpochW = 8;

    logic clk = 1'b0;
    logic rst, start, sample_valid, yEqualt, flagEOF;
    logic sample_ready, epoch_start, reset, ldRegN, ldRegx1, ldRegx2, ldRegT;
    logic ldRegW1, ldRegW2, ldRegB, ldRegFlag, counterEn, counterReset, flagReset;
    logic busy, done, converged;
    logic [EpochW-1:0] epochs;

    always #5 clk = ~clk;

    neuron_train_ctrl #(
        .EPOCH_W   (EpochW),
        .MAX_EPOCHS(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .epoch_start (epoch_start),
        .yEqualt     (yEqualt),
        .flagEOF     (flagEOF),
        .reset       (reset),
        .ldRegN      (ldRegN),
        .ldRegx1     (ldRegx1),
        .ldRegx2     (ldRegx2),
        .ldRegT      (ldRegT),
        .ldRegW1     (ldRegW1),
        .ldRegW2     (ldRegW2),
        .ldRegB      (ldRegB),
        .ldRegFlag   (ldRegFlag),
        .counterEn   (counterEn),
        .counterReset(counterReset),
        .flagReset   (flagReset),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .epochs      (epochs)
    );

    // Minimal datapath model: sample counter, N register, epoch index for yEqualt shaping.
    logic [19:0] nIn, nReg, cnt;
    int yMode;
    int epochNum;
    always @(posedge clk) begin
        if (ldRegN) nReg <= nIn;
        if (counterReset) cnt <= '0;
        else if (counterEn) cnt <= cnt + 1'b1;
        if (ldRegN) epochNum <= 0;
        else if (epoch_start) epochNum <= epochNum + 1;
    end
    assign flagEOF = (cnt == nReg);
    // Mode 0: always match; 1: never match; 2: only sample 0 of epoch 0 mismatches.
    assign yEqualt = (yMode == 1) ? 1'b0 :
                     (yMode == 2 && epochNum == 0 && cnt == 0) ? 1'b0 : 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
    } point_t;
    typedef struct {
        int expCyc;
        int conv;
        int ep;
        int hs;
        int wt;
        int es;
    } run_t;

    point_t pointQ[$];
    run_t   runQ[$];

    int checks = 0;
    int errors = 0;
    int hsCnt = 0, wtCnt = 0, esCnt = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
        end
    endtask

    task automatic checkPoint(input point_t p);
        if (p.cyc != cyc) begin
            check("point_missed", p.cyc, cyc);
        end else begin
            case (p.kind)
                0: check("idle_outputs",
                         int'({busy, done, converged, epochs, sample_ready, epoch_start, reset,
                               ldRegN, ldRegx1, ldRegx2, ldRegT, ldRegW1, ldRegW2, ldRegB,
                               ldRegFlag, counterEn, counterReset, flagReset}), 0);
                1: check("init_strobes",
                         int'({busy, reset, ldRegN, counterReset, flagReset, sample_ready,
                               counterEn}), 7'b1111100);
                2: check("post_init_strobes",
                         int'({busy, reset, ldRegN, counterReset, flagReset}), 5'b10000);
                default: check("fetch_stall",
                         int'({busy, sample_ready, ldRegx1, ldRegx2, ldRegT}), 5'b11000);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            hsCnt = 0;
            wtCnt = 0;
            esCnt = 0;
        end else begin
            if (ldRegx1 && ldRegx2 && ldRegT) hsCnt++;
            if (ldRegW1 && ldRegW2 && ldRegB) wtCnt++;
            if (epoch_start) esCnt++;
        end
        while (pointQ.size() > 0 && pointQ[0].cyc <= cyc) begin
            checkPoint(pointQ.pop_front());
        end
        if (done === 1'b1) begin
            if (runQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                run_t r;
                r = runQ.pop_front();
                check("done_cycle", cyc, r.expCyc);
                check("converged", int'(converged), r.conv);
                check("epochs", int'(epochs), r.ep);
                check("handshakes", hsCnt, r.hs);
                check("weight_updates", wtCnt, r.wt);
                check("epoch_starts", esCnt, r.es);
            end
            hsCnt = 0;
            wtCnt = 0;
            esCnt = 0;
        end
        if (runQ.size() > 0 && cyc > runQ[0].expCyc + 40) begin
            check("done_timeout", 0, 1);
            void'(runQ.pop_front());
        end
    end

    task automatic pushPoint(input int c, input int kind);
        point_t p;
        p.cyc  = c;
        p.kind = kind;
        pointQ.push_back(p);
    endtask

    task automatic pushRun(input int lat, input int conv, input int ep, input int hs,
                           input int wt, input int es);
        run_t r;
        r.expCyc = cyc + 1 + lat;
        r.conv   = conv;
        r.ep     = ep;
        r.hs     = hs;
        r.wt     = wt;
        r.es     = es;
        runQ.push_back(r);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge with the DUT idle.
    task automatic runTrain(input int n, input int mode, input int lat, input int conv,
                            input int ep, input int hs, input int wt, input int es);
        nIn          = 20'(n);
        yMode        = mode;
        sample_valid = 1'b1;
        pushRun(lat, conv, ep, hs, wt, es);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone();
    endtask

    initial begin
        int c;
        rst          = 1'b0;
        start        = 1'b1;
        sample_valid = 1'b1;
        nIn          = 20'd3;
        yMode        = 0;
        pushPoint(1, 0);
        pushPoint(2, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        pushPoint(cyc + 1, 1);
        pushPoint(cyc + 2, 2);
        // N=3, always correct: 1 INIT + 1 CHECK + 3*3 + 1 EPOCH_END.
        runTrain(3, 0, 12, 1, 1, 3, 0, 0);
        // N=2, one early mistake: second epoch clean.
        runTrain(2, 2, 16, 1, 2, 4, 1, 1);
        // N=1, never correct: stops at the 4-epoch limit.
        runTrain(1, 1, 18, 0, 4, 4, 4, 3);
        // N=0: INIT, CHECK, EPOCH_END, DONE.
        runTrain(0, 0, 3, 1, 1, 0, 0, 0);

        // Five idle sample_valid cycles in FETCH plus a start pulse while busy.
        nIn          = 20'd3;
        yMode        = 0;
        sample_valid = 1'b0;
        pushRun(17, 1, 1, 3, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) break;
        end
        c = cyc;
        for (int i = 1; i <= 4; i++) pushPoint(c + i, 3);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 sample_valid = 1'b1;
        waitDone();

        // Reset asserted during EVAL discards the run.
        nIn   = 20'd3;
        yMode = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ldRegFlag === 1'b1) break;
        end
        c   = cyc;
        rst = 1'b0;
        pushPoint(c + 1, 0);
        pushPoint(c + 2, 0);
        pushPoint(c + 3, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        runTrain(0, 0, 3, 1, 1, 0, 0, 0);

        repeat (50) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
